// File: rtl/display_source_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : display_source_mux_if
//  Purpose  : Pixel-source, marker-control and TCON write-word bundle for
//             display_source_mux.
//  Revision : 1.0  initial release
// ============================================================================
interface display_source_mux_if #(
   parameter int NUM_SRC = 8,
   parameter int CH_W    = 12,
   parameter int SEL_W   = 3
);
   logic [SEL_W-1:0]          iSelect;
   logic [15:0]               iX_Cont;
   logic [15:0]               iY_Cont;
   logic                      iValid;
   logic [NUM_SRC*3*CH_W-1:0] iSrc_RGB;
   logic [7:0]                iMarkLevel;
   logic                      iMarkEn;
   logic [15:0]               oWr1_data;
   logic [15:0]               oWr2_data;
   logic                      oValid;
   logic [SEL_W-1:0]          oSelActive;
   logic                      oSelPending;

   modport master (
      output iSelect, iX_Cont, iY_Cont, iValid, iSrc_RGB, iMarkLevel, iMarkEn,
      input  oWr1_data, oWr2_data, oValid, oSelActive, oSelPending
   );

   modport slave (
      input  iSelect, iX_Cont, iY_Cont, iValid, iSrc_RGB, iMarkLevel, iMarkEn,
      output oWr1_data, oWr2_data, oValid, oSelActive, oSelPending
   );
endinterface
`default_nettype wire

// File: rtl/display_source_mux.sv
`default_nettype none
// ============================================================================
//  Module   : display_source_mux
//  Purpose  : Frame-synchronous pixel source selector with row-marker overlay,
//             packing into two 16-bit TCON write words (2-cycle latency).
//  Revision : 1.0  initial release
// ============================================================================
module display_source_mux #(
   parameter int                 NUM_SRC     = 8,
   parameter int                 CH_W        = 12,
   parameter int                 SEL_W       = 3,
   parameter int                 DEFAULT_SEL = 1,
   parameter logic [NUM_SRC-1:0] MARK_MASK   = 'h04,
   parameter int                 MARK_BASE   = 255
) (
   input  wire logic              iClk,
   input  wire logic              iRst,
   display_source_mux_if.slave    bus
);

   localparam int               c_PIX_W       = 3 * CH_W;
   localparam logic [15:0]      c_MARK_BASE   = 16'(MARK_BASE);
   localparam logic [SEL_W-1:0] c_DEFAULT_SEL = SEL_W'(DEFAULT_SEL);

   logic [SEL_W-1:0]   sel_active_q, sel_active_d;
   logic               sel_pending_q;
   logic [c_PIX_W-1:0] rgb1_q, rgb1_d;
   logic [15:0]        row1_q;
   logic               mark_ok1_q, mark_ok1_d;
   logic               valid1_q;
   logic [15:0]        wr1_q, wr2_q;
   logic               valid2_q;

   logic               w_sel_ok;
   logic [CH_W-1:0]    w_r2, w_g2, w_b2;
   logic [15:0]        w_mark_row;
   logic               w_unused_lsb;

   // The select sampled at frame start already governs the frame-start pixel.
   always_comb begin
      sel_active_d = sel_active_q;
      if (bus.iValid && (bus.iX_Cont == 16'd0) && (bus.iY_Cont == 16'd0))
         sel_active_d = bus.iSelect;
   end

   always_comb begin
      rgb1_d     = '0;
      mark_ok1_d = 1'b0;
      w_sel_ok   = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if ({{(32-SEL_W){1'b0}}, sel_active_d} == 32'(k + 1)) begin
            w_sel_ok   = 1'b1;
            mark_ok1_d = MARK_MASK[k];
            if (bus.iValid)
               rgb1_d = bus.iSrc_RGB[(k*3+3)*CH_W-1 -: c_PIX_W];
         end
      end
      // Unknown code shows white even on blank cycles so a bad select is visible.
      if (!w_sel_ok)
         rgb1_d = '1;
   end

   always_comb begin
      w_mark_row        = c_MARK_BASE - row1_q;
      {w_r2, w_g2, w_b2} = rgb1_q;
      if (valid1_q && bus.iMarkEn && mark_ok1_q && (w_mark_row == {8'b0, bus.iMarkLevel})) begin
         w_r2 = '1;
         w_g2 = '0;
         w_b2 = '0;
      end
   end

   assign w_unused_lsb = ^{w_r2, w_g2, w_b2};

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         sel_active_q  <= c_DEFAULT_SEL;
         sel_pending_q <= 1'b0;
         rgb1_q        <= '0;
         row1_q        <= '0;
         mark_ok1_q    <= 1'b0;
         valid1_q      <= 1'b0;
         wr1_q         <= '0;
         wr2_q         <= '0;
         valid2_q      <= 1'b0;
      end else begin
         sel_active_q  <= sel_active_d;
         sel_pending_q <= (bus.iSelect != sel_active_d);
         rgb1_q        <= rgb1_d;
         row1_q        <= bus.iY_Cont;
         mark_ok1_q    <= mark_ok1_d;
         valid1_q      <= bus.iValid;
         wr1_q         <= {w_g2[CH_W-1 -: 5], w_b2[CH_W-1 -: 10], 1'b0};
         wr2_q         <= {w_g2[CH_W-6 -: 5], w_r2[CH_W-1 -: 10], 1'b0};
         valid2_q      <= valid1_q;
      end
   end

   assign bus.oWr1_data   = wr1_q;
   assign bus.oWr2_data   = wr2_q;
   assign bus.oValid      = valid2_q;
   assign bus.oSelActive  = sel_active_q;
   assign bus.oSelPending = sel_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_display_source_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_source_mux
//  Purpose  : Directed self-checking bench for display_source_mux.
//  Revision : 1.0  initial release
// ============================================================================
module tb_display_source_mux;

   localparam int         NUM_SRC = 8;
   localparam int         CH_W    = 12;
   localparam int         SEL_W   = 3;
   localparam logic [7:0] MMASK   = 8'h04;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   display_source_mux_if #(.NUM_SRC(NUM_SRC), .CH_W(CH_W), .SEL_W(SEL_W)) ifc();

   display_source_mux #(
      .NUM_SRC(NUM_SRC), .CH_W(CH_W), .SEL_W(SEL_W),
      .DEFAULT_SEL(1), .MARK_MASK(MMASK), .MARK_BASE(255)
   ) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (ifc)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [35:0] src [NUM_SRC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic load_src();
      for (int k = 0; k < NUM_SRC; k++)
         ifc.iSrc_RGB[(k*3+3)*CH_W-1 -: 36] = src[k];
   endtask

   task automatic px(input logic v, input int x, input int y);
      ifc.iValid  = v;
      ifc.iX_Cont = 16'(x);
      ifc.iY_Cont = 16'(y);
      @(posedge clk);
      #1;
   endtask

   // Spec-level model: what pixel does a select code show for a given input?
   function automatic logic [35:0] pick(input logic v, input logic [2:0] s,
                                        input logic [NUM_SRC*36-1:0] all);
      if (int'(s) < 1 || int'(s) > NUM_SRC) return '1;
      if (!v) return '0;
      return all[int'(s)*36-1 -: 36];
   endfunction

   function automatic logic [31:0] pack(input logic [35:0] p);
      logic [11:0] r, g, b;
      {r, g, b} = p;
      return {g[11:7], b[11:2], 1'b0, g[6:2], r[11:2], 1'b0};
   endfunction

   logic [2:0]  m_sel;
   logic        m_v1;
   logic [2:0]  m_s1;
   logic [35:0] m_p1;
   logic [15:0] m_row1;
   logic [31:0] m_out;
   logic        m_ov;
   logic        m_pend;
   bit          m_live = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_sel = 3'd1; m_v1 = 1'b0; m_s1 = 3'd1; m_p1 = '0; m_row1 = '0;
         m_out = '0;   m_ov = 1'b0; m_pend = 1'b0; m_live = 1'b1;
      end else begin
         logic [35:0] p;
         p = m_p1;
         if (m_v1 && ifc.iMarkEn && m_s1 >= 3'd1 && MMASK[m_s1 - 3'd1] &&
             (16'd255 - m_row1) == {8'd0, ifc.iMarkLevel})
            p = {12'hFFF, 24'h0};
         m_out = pack(p);
         m_ov  = m_v1;
         if (ifc.iValid && ifc.iX_Cont == 16'd0 && ifc.iY_Cont == 16'd0)
            m_sel = ifc.iSelect;
         m_v1   = ifc.iValid;
         m_s1   = m_sel;
         m_p1   = pick(ifc.iValid, m_sel, ifc.iSrc_RGB);
         m_row1 = ifc.iY_Cont;
         m_pend = (ifc.iSelect != m_sel);
      end
   end

   always @(negedge clk) begin
      if (m_live && !rst) begin
         chk("wr1",        32'(ifc.oWr1_data),   32'(m_out[31:16]));
         chk("wr2",        32'(ifc.oWr2_data),   32'(m_out[15:0]));
         chk("valid",      32'(ifc.oValid),      32'(m_ov));
         chk("sel_active", 32'(ifc.oSelActive),  32'(m_sel));
         chk("pending",    32'(ifc.oSelPending), 32'(m_pend));
      end
   end

   initial begin
      src[0] = {12'hFFF, 12'h000, 12'h000};
      src[1] = {12'hABC, 12'h5A5, 12'h3C3};
      src[2] = {12'h123, 12'h456, 12'h789};
      for (int k = 3; k < NUM_SRC; k++)
         src[k] = {12'(k*37+1), 12'(k*91+2), 12'(k*53+3)};
      ifc.iSrc_RGB   = '0;
      load_src();
      ifc.iSelect    = 3'd1;
      ifc.iValid     = 1'b0;
      ifc.iX_Cont    = '0;
      ifc.iY_Cont    = '0;
      ifc.iMarkLevel = 8'd0;
      ifc.iMarkEn    = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // latency: red source, 2 cycles to output
      px(1, 0, 0);
      px(0, 1, 0);
      chk("T2 wr2", 32'(ifc.oWr2_data), 32'h07FE);
      chk("T2 wr1", 32'(ifc.oWr1_data), 32'h0000);
      chk("T2 valid", 32'(ifc.oValid), 32'd1);
      for (int x = 1; x < 5; x++) px(1, x, 0);

      // tear-free change 1 -> 2 mid-frame
      px(1, 99, 50);
      ifc.iSelect = 3'd2;
      px(1, 100, 50);
      px(1, 101, 50);
      chk("T3 pending", 32'(ifc.oSelPending), 32'd1);
      chk("T3 still src0", 32'(ifc.oWr2_data), 32'h07FE);
      chk("T3 sel held", 32'(ifc.oSelActive), 32'd1);
      px(1, 102, 50);
      px(1, 0, 0);
      px(0, 1, 0);
      chk("T3 src1 wr1", 32'(ifc.oWr1_data), 32'h59E0);
      chk("T3 src1 wr2", 32'(ifc.oWr2_data), 32'h4D5E);
      chk("T3 pending clr", 32'(ifc.oSelPending), 32'd0);

      // valid gaps with sel=2
      px(0, 2, 0);
      px(1, 2, 0);
      chk("T6 gap valid", 32'(ifc.oValid), 32'd0);
      chk("T6 gap wr1", 32'(ifc.oWr1_data), 32'h0000);
      px(1, 3, 0);
      chk("T6 resume wr1", 32'(ifc.oWr1_data), 32'h59E0);
      ifc.iSelect = 3'd5;
      px(1, 4, 0);
      ifc.iSelect = 3'd2;
      px(1, 5, 0);
      px(0, 6, 0);

      // marker overlay on select 3
      ifc.iSelect    = 3'd3;
      ifc.iMarkEn    = 1'b1;
      ifc.iMarkLevel = 8'd200;
      px(1, 0, 0);
      px(1, 0, 55);
      px(1, 1, 56);
      chk("T4 marker wr1", 32'(ifc.oWr1_data), 32'h0000);
      chk("T4 marker wr2", 32'(ifc.oWr2_data), 32'h07FE);
      px(1, 2, 56);
      chk("T4 plain wr1", 32'(ifc.oWr1_data), 32'h43C4);
      chk("T4 plain wr2", 32'(ifc.oWr2_data), 32'hA890);
      px(1, 3, 300);
      px(1, 4, 300);

      // same row with select 1: no marker (src0 now pure green)
      src[0] = {12'h000, 12'hFFF, 12'h000};
      load_src();
      ifc.iSelect = 3'd1;
      px(1, 0, 0);
      px(1, 0, 55);
      px(0, 1, 55);
      chk("T4 no marker wr1", 32'(ifc.oWr1_data), 32'hF800);
      ifc.iMarkEn = 1'b0;

      // invalid code 0 -> white even on blank cycles
      ifc.iSelect = 3'd0;
      px(1, 0, 0);
      px(0, 5, 5);
      px(0, 6, 5);
      chk("T5 wr1", 32'(ifc.oWr1_data), 32'hFFFE);
      chk("T5 wr2", 32'(ifc.oWr2_data), 32'hFFFE);
      chk("T5 valid", 32'(ifc.oValid), 32'd0);
      chk("T5 sel", 32'(ifc.oSelActive), 32'd0);
      px(1, 7, 5);

      // asynchronous reset mid-stream
      rst = 1'b1;
      #1;
      chk("T1 wr1", 32'(ifc.oWr1_data), 32'h0000);
      chk("T1 wr2", 32'(ifc.oWr2_data), 32'h0000);
      chk("T1 valid", 32'(ifc.oValid), 32'd0);
      chk("T1 sel", 32'(ifc.oSelActive), 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int x = 8; x < 12; x++) px(1, x, 5);
      ifc.iSelect = 3'd4;
      px(1, 0, 0);
      for (int x = 1; x < 6; x++) px(x[0], x, 0);
      px(0, 6, 0);
      px(0, 7, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
